// File: rtl/sys_cmd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sys_cmd_pkg
// Shared definitions for the UART command controller:
//   - command code bytes recognised in the idle state
//   - register-file addresses that receive the ALU operands
//   - state encodings for the frame decoder and the response transmitter
//   - decode_cmd(): maps a command byte to the decoder's next state
// ---------------------------------------------------------------------------
package sys_cmd_pkg;

  // Command codes (first byte of every frame)
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;  // addr, data
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;  // addr
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // A, B, fun
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // fun

  // Register-file locations the ALU reads its operands from
  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  // Frame decoder states. ST_RESP covers the whole SEND/WAIT sequence,
  // which is sequenced by sys_resp_tx.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_RESP
  } ctrl_state_t;

  // Response transmitter states
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SEND0,
    TX_WAIT0,
    TX_SEND1,
    TX_WAIT1
  } tx_state_t;

  // Unknown command bytes leave the decoder in idle.
  function automatic ctrl_state_t decode_cmd(input logic [7:0] cmd);
    ctrl_state_t nxt;
    case (cmd)
      CMD_RF_WR:   nxt = ST_WR_ADDR;
      CMD_RF_RD:   nxt = ST_RD_ADDR;
      CMD_ALU_OP:  nxt = ST_ALU_A;
      CMD_ALU_NOP: nxt = ST_ALU_FUN;
      default:     nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sys_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// sys_cmd_ctrl_if
// Bundles every bus the command controller talks to:
//   Rx_P_Data / Rx_Data_valid        bytes from the UART receiver
//   RF_Address / RF_WrEn / RF_RdEn /
//   RF_WrData / RF_RdData /
//   RF_RdData_valid                  register-file access
//   Clk_gate_EN / ALU_EN / ALU_FUN /
//   ALU_OUT / ALU_OUT_valid          ALU control and result
//   Tx_P_Data / Tx_Data_valid /
//   Tx_busy                          bytes to the UART transmitter
// modport master : the controller side
// modport slave  : the environment (UART, register file, ALU)
// ---------------------------------------------------------------------------
interface sys_cmd_ctrl_if #(
  parameter int width      = 8,
  parameter int addr_width = 4
);

  logic [width-1:0]      Rx_P_Data;
  logic                  Rx_Data_valid;

  logic [addr_width-1:0] RF_Address;
  logic                  RF_WrEn;
  logic                  RF_RdEn;
  logic [width-1:0]      RF_WrData;
  logic [width-1:0]      RF_RdData;
  logic                  RF_RdData_valid;

  logic                  Clk_gate_EN;
  logic                  ALU_EN;
  logic [3:0]            ALU_FUN;
  logic [2*width-1:0]    ALU_OUT;
  logic                  ALU_OUT_valid;

  logic [width-1:0]      Tx_P_Data;
  logic                  Tx_Data_valid;
  logic                  Tx_busy;

  modport master (
    input  Rx_P_Data, Rx_Data_valid,
    output RF_Address, RF_WrEn, RF_RdEn, RF_WrData,
    input  RF_RdData, RF_RdData_valid,
    output Clk_gate_EN, ALU_EN, ALU_FUN,
    input  ALU_OUT, ALU_OUT_valid,
    output Tx_P_Data, Tx_Data_valid,
    input  Tx_busy
  );

  modport slave (
    output Rx_P_Data, Rx_Data_valid,
    input  RF_Address, RF_WrEn, RF_RdEn, RF_WrData,
    output RF_RdData, RF_RdData_valid,
    input  Clk_gate_EN, ALU_EN, ALU_FUN,
    output ALU_OUT, ALU_OUT_valid,
    input  Tx_P_Data, Tx_Data_valid,
    output Tx_busy
  );

endinterface

// File: rtl/sys_cmd_ctrl_resp_tx.sv
// ---------------------------------------------------------------------------
// sys_resp_tx
// Sends a one- or two-byte response to the UART transmitter.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle request; payload and two_byte are captured with it
//   two_byte    1: send payload[7:0] then payload[15:8]; 0: low byte only
//   payload     response word
//   tx_busy     transmitter busy
//   done        one-cycle strobe (combinational) as the last byte completes
//   tx_data     registered byte held for the transmitter
//   tx_valid    registered one-cycle transmit request
// ---------------------------------------------------------------------------
module sys_resp_tx
  import sys_cmd_pkg::*;
#(
  parameter int width = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               two_byte,
  input  logic [2*width-1:0] payload,
  input  logic               tx_busy,
  output logic               done,
  output logic [width-1:0]   tx_data,
  output logic               tx_valid
);

  tx_state_t          state_q, state_d;
  logic [2*width-1:0] cap_q, cap_d;
  logic               two_q, two_d;
  logic               first_q, first_d;
  logic [width-1:0]   data_q, data_d;
  logic               valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cap_q   <= '0;
      two_q   <= 1'b0;
      first_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      two_q   <= two_d;
      first_q <= first_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    two_d   = two_q;
    first_d = 1'b0;
    data_d  = data_q;
    valid_d = 1'b0;
    done    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (start) begin
          cap_d   = payload;
          two_d   = two_byte;
          state_d = TX_SEND0;
        end
      end
      TX_SEND0: begin
        if (!tx_busy) begin
          data_d  = cap_q[width-1:0];
          valid_d = 1'b1;
          first_d = 1'b1;
          state_d = TX_WAIT0;
        end
      end
      TX_WAIT0: begin
        // The transmitter only raises busy after seeing the request, so the
        // first cycle's busy value carries no information.
        if (!first_q && !tx_busy) begin
          if (two_q) begin
            state_d = TX_SEND1;
          end else begin
            state_d = TX_IDLE;
            done    = 1'b1;
          end
        end
      end
      TX_SEND1: begin
        if (!tx_busy) begin
          data_d  = cap_q[2*width-1:width];
          valid_d = 1'b1;
          first_d = 1'b1;
          state_d = TX_WAIT1;
        end
      end
      TX_WAIT1: begin
        if (!first_q && !tx_busy) begin
          state_d = TX_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign tx_data  = data_q;
  assign tx_valid = valid_q;

endmodule

// File: rtl/sys_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// sys_cmd_ctrl
// Decodes framed commands from the UART receiver into register-file writes
// and reads and ALU operations, gates the ALU clock around each operation,
// and returns read data / ALU results to the UART transmitter.
//   CLK    system clock
//   Reset  asynchronous active-low reset
//   bus    sys_cmd_ctrl_if.master: Rx byte input, register-file port,
//          ALU control/result, Tx byte handshake
// Frames: AA addr data | BB addr | CC A B fun | DD fun
// All outputs are registered.
// ---------------------------------------------------------------------------
module sys_cmd_ctrl
  import sys_cmd_pkg::*;
#(
  parameter int width      = 8,
  parameter int addr_width = 4
) (
  input  logic           CLK,
  input  logic           Reset,
  sys_cmd_ctrl_if.master bus
);

  ctrl_state_t           state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [width-1:0]      wrdata_q, wrdata_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  gate_q, gate_d;
  logic                  alu_en_q, alu_en_d;
  logic [3:0]            fun_q, fun_d;
  logic                  pend_q, pend_d;

  logic                  resp_start;
  logic                  resp_two;
  logic [2*width-1:0]    resp_payload;
  logic                  resp_done;
  logic [width-1:0]      tx_data;
  logic                  tx_valid;

  logic [width-1:0]      rx_byte;
  logic                  rx_vld;

  assign rx_byte = bus.Rx_P_Data;
  assign rx_vld  = bus.Rx_Data_valid;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wrdata_q <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      gate_q   <= 1'b0;
      alu_en_q <= 1'b0;
      fun_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      gate_q   <= gate_d;
      alu_en_q <= alu_en_d;
      fun_q    <= fun_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wrdata_d     = wrdata_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    gate_d       = gate_q;
    alu_en_d     = 1'b0;
    fun_d        = fun_q;
    pend_d       = pend_q;
    resp_start   = 1'b0;
    resp_two     = 1'b0;
    resp_payload = '0;
    case (state_q)
      ST_IDLE: begin
        if (rx_vld) state_d = decode_cmd(rx_byte[7:0]);
      end
      ST_WR_ADDR: begin
        if (rx_vld) begin
          addr_d  = rx_byte[addr_width-1:0];
          state_d = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        // Back in idle while the strobe is out, so a new command byte can
        // follow immediately.
        if (rx_vld) begin
          wrdata_d = rx_byte;
          wr_en_d  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (rx_vld) begin
          addr_d  = rx_byte[addr_width-1:0];
          rd_en_d = 1'b1;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (bus.RF_RdData_valid) begin
          resp_start   = 1'b1;
          resp_payload = {{width{1'b0}}, bus.RF_RdData};
          state_d      = ST_RESP;
        end
      end
      ST_ALU_A: begin
        if (rx_vld) begin
          addr_d   = addr_width'(OPA_ADDR);
          wrdata_d = rx_byte;
          wr_en_d  = 1'b1;
          state_d  = ST_ALU_B;
        end
      end
      ST_ALU_B: begin
        if (rx_vld) begin
          addr_d   = addr_width'(OPB_ADDR);
          wrdata_d = rx_byte;
          wr_en_d  = 1'b1;
          state_d  = ST_ALU_FUN;
        end
      end
      ST_ALU_FUN: begin
        // Ungate the ALU clock first; the start pulse follows one cycle
        // later so the ALU sees a running clock when it is enabled.
        if (rx_vld) begin
          fun_d   = rx_byte[3:0];
          gate_d  = 1'b1;
          pend_d  = 1'b1;
          state_d = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        if (pend_q) begin
          alu_en_d = 1'b1;
          pend_d   = 1'b0;
        end else if (bus.ALU_OUT_valid) begin
          // Gate is dropped at the edge that captures the result.
          gate_d       = 1'b0;
          resp_start   = 1'b1;
          resp_two     = 1'b1;
          resp_payload = bus.ALU_OUT;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  sys_resp_tx #(
    .width (width)
  ) u_resp_tx (
    .clk      (CLK),
    .rst_n    (Reset),
    .start    (resp_start),
    .two_byte (resp_two),
    .payload  (resp_payload),
    .tx_busy  (bus.Tx_busy),
    .done     (resp_done),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  assign bus.RF_Address    = addr_q;
  assign bus.RF_WrEn       = wr_en_q;
  assign bus.RF_RdEn       = rd_en_q;
  assign bus.RF_WrData     = wrdata_q;
  assign bus.Clk_gate_EN   = gate_q;
  assign bus.ALU_EN        = alu_en_q;
  assign bus.ALU_FUN       = fun_q;
  assign bus.Tx_P_Data     = tx_data;
  assign bus.Tx_Data_valid = tx_valid;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sys_cmd_ctrl
// Directed bench for sys_cmd_ctrl: drives command frames byte by byte,
// plays register file / ALU / transmitter by hand, and compares the
// recorded strobes and transmitted bytes with hand-computed values.
// ---------------------------------------------------------------------------
module tb_sys_cmd_ctrl;

  logic clk;
  logic rst_n;

  sys_cmd_ctrl_if #(.width(8), .addr_width(4)) bus ();

  sys_cmd_ctrl #(.width(8), .addr_width(4)) dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observations recorded mid-cycle
  logic [15:0] wr_q[$];
  logic [7:0]  tx_q[$];
  int          rd_cnt = 0;
  int          alu_cnt = 0;
  logic [3:0]  rd_addr = '0;
  logic [3:0]  alu_fun = '0;
  logic        gate_at_en = 1'b0;
  int          wr_cyc = 0, rd_cyc = 0, alu_cyc = 0, tx_cyc = 0;

  always @(negedge clk) begin
    if (bus.RF_WrEn) begin
      wr_q.push_back({4'h0, bus.RF_Address, bus.RF_WrData});
      wr_cyc = cyc;
    end
    if (bus.RF_RdEn) begin
      rd_cnt++;
      rd_addr = bus.RF_Address;
      rd_cyc  = cyc;
    end
    if (bus.ALU_EN) begin
      alu_cnt++;
      alu_fun    = bus.ALU_FUN;
      gate_at_en = bus.Clk_gate_EN;
      alu_cyc    = cyc;
    end
    if (bus.Tx_Data_valid) begin
      tx_q.push_back(bus.Tx_P_Data);
      tx_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.Rx_P_Data     = b;
    bus.Rx_Data_valid = 1'b1;
    @(negedge clk);
    bus.Rx_Data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, tx_q.size(), n);
  endtask

  task automatic wait_alu(input string tag, input int n, input int budget);
    int k = 0;
    while (alu_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, alu_cnt, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n               = 1'b0;
    bus.Rx_P_Data       = '0;
    bus.Rx_Data_valid   = 1'b0;
    bus.RF_RdData       = '0;
    bus.RF_RdData_valid = 1'b0;
    bus.ALU_OUT         = '0;
    bus.ALU_OUT_valid   = 1'b0;
    bus.Tx_busy         = 1'b0;

    // Reset state
    idle(3);
    check("rst_wren",    bus.RF_WrEn, 0);
    check("rst_rden",    bus.RF_RdEn, 0);
    check("rst_addr",    bus.RF_Address, 0);
    check("rst_wrdata",  bus.RF_WrData, 0);
    check("rst_gate",    bus.Clk_gate_EN, 0);
    check("rst_alu_en",  bus.ALU_EN, 0);
    check("rst_alu_fun", bus.ALU_FUN, 0);
    check("rst_tx_data", bus.Tx_P_Data, 0);
    check("rst_tx_vld",  bus.Tx_Data_valid, 0);
    rst_n = 1'b1;
    idle(2);

    // RF write followed immediately by a second write frame
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    send_byte(8'hAA); send_byte(8'h0A); send_byte(8'h5A);
    idle(3);
    check("wr_count",  wr_q.size(), 2);
    check("wr0",       wr_q[0], 16'h053C);
    check("wr1_b2b",   wr_q[1], 16'h0A5A);
    check("wr_no_tx",  tx_q.size(), 0);
    check("wr_no_rd",  rd_cnt, 0);

    // RF read
    wr_q.delete();
    send_byte(8'hBB);
    c = cyc;
    send_byte(8'h07);
    idle(2);
    check("rd_count",   rd_cnt, 1);
    check("rd_addr",    rd_addr, 4'h7);
    check("rd_latency", rd_cyc - c, 1);
    bus.RF_RdData       = 8'h9E;
    bus.RF_RdData_valid = 1'b1;
    c = cyc;
    @(negedge clk);
    bus.RF_RdData_valid = 1'b0;
    wait_tx("rd_tx_seen", 1, 20);
    idle(6);
    check("rd_tx_count",   tx_q.size(), 1);
    check("rd_tx_byte",    tx_q[0], 8'h9E);
    check("rd_tx_latency", tx_cyc - c, 2);
    check("rd_no_wr",      wr_q.size(), 0);

    // ALU with operands, plus bytes dropped while waiting for the result
    tx_q.delete();
    send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34);
    c = cyc;
    send_byte(8'h01);
    wait_alu("alu_en_seen", 1, 10);
    check("alu_latency", alu_cyc - c, 2);
    check("alu_fun",     alu_fun, 4'h1);
    check("alu_gate_on", gate_at_en, 1);
    check("alu_wr_cnt",  wr_q.size(), 2);
    check("alu_opa",     wr_q[0], 16'h0012);
    check("alu_opb",     wr_q[1], 16'h0134);
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h44);
    idle(2);
    check("alu_wait_drop", wr_q.size(), 2);
    bus.ALU_OUT       = 16'h0046;
    bus.ALU_OUT_valid = 1'b1;
    @(negedge clk);
    bus.ALU_OUT_valid = 1'b0;
    wait_tx("alu_tx_seen", 2, 30);
    idle(6);
    check("alu_tx_count", tx_q.size(), 2);
    check("alu_tx_lo",    tx_q[0], 8'h46);
    check("alu_tx_hi",    tx_q[1], 8'h00);
    check("alu_gate_off", bus.Clk_gate_EN, 0);
    check("alu_no_rd",    rd_cnt, 1);

    // Transmit backpressure on an operand-less ALU command
    tx_q.delete();
    wr_q.delete();
    send_byte(8'hDD); send_byte(8'h02);
    wait_alu("bp_alu_en_seen", 2, 10);
    check("bp_alu_fun", alu_fun, 4'h2);
    bus.Tx_busy       = 1'b1;
    bus.ALU_OUT       = 16'h1234;
    bus.ALU_OUT_valid = 1'b1;
    @(negedge clk);
    bus.ALU_OUT_valid = 1'b0;
    idle(50);
    check("bp_held",     tx_q.size(), 0);
    check("bp_gate_off", bus.Clk_gate_EN, 0);
    bus.Tx_busy = 1'b0;
    wait_tx("bp_tx_seen", 2, 30);
    idle(6);
    check("bp_tx_count", tx_q.size(), 2);
    check("bp_tx_lo",    tx_q[0], 8'h34);
    check("bp_tx_hi",    tx_q[1], 8'h12);
    check("bp_no_wr",    wr_q.size(), 0);

    // Unknown command byte ahead of a write
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
    idle(3);
    check("unk_wr_count", wr_q.size(), 1);
    check("unk_wr",       wr_q[0], 16'h01FF);

    // Reset in the middle of an ALU frame
    wr_q.delete();
    tx_q.delete();
    send_byte(8'hCC); send_byte(8'h12);
    idle(1);
    check("mid_wr_before_rst", wr_q.size(), 1);
    rst_n = 1'b0;
    #2;
    check("mrst_wrdata",  bus.RF_WrData, 0);
    check("mrst_addr",    bus.RF_Address, 0);
    check("mrst_alu_fun", bus.ALU_FUN, 0);
    check("mrst_tx_data", bus.Tx_P_Data, 0);
    check("mrst_gate",    bus.Clk_gate_EN, 0);
    check("mrst_wren",    bus.RF_WrEn, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_q.delete();
    send_byte(8'hAA); send_byte(8'h02);
    c = cyc;
    send_byte(8'h11);
    idle(3);
    check("post_rst_wr_cnt", wr_q.size(), 1);
    check("post_rst_wr",     wr_q[0], 16'h0211);
    check("post_rst_wr_lat", wr_cyc - c, 1);
    check("post_rst_no_alu", alu_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sys_cmd_ctrl.md
# sys_cmd_ctrl

Command controller sitting directly downstream of the UART receiver. It consumes received bytes (`P_Data` qualified by `Data_valid`) and decodes framed commands into register-file write/read and ALU requests. It gates the ALU clock for low power and returns read data or ALU results to the UART transmitter through a byte handshake.

## Interface
Parameters:
- `width`, 8, UART byte and register-file data width
- `addr_width`, 4, register-file address width

Ports:
- `CLK`  in  1  system clock
- `Reset`  in  1  asynchronous, active-low reset
- `Rx_P_Data`  in  width  received byte, valid only with `Rx_Data_valid`
- `Rx_Data_valid`  in  1  single-cycle pulse per error-free received byte
- `RF_Address`  out  addr_width  register-file address
- `RF_WrEn`  out  1  single-cycle write strobe
- `RF_RdEn`  out  1  single-cycle read strobe
- `RF_WrData`  out  width  write data
- `RF_RdData`  in  width  read data
- `RF_RdData_valid`  in  1  read data qualifier, one-cycle pulse
- `Clk_gate_EN`  out  1  ALU clock-gate enable
- `ALU_EN`  out  1  single-cycle ALU start
- `ALU_FUN`  out  4  ALU function code
- `ALU_OUT`  in  2*width  ALU result
- `ALU_OUT_valid`  in  1  result qualifier, one-cycle pulse
- `Tx_P_Data`  out  width  byte to transmit
- `Tx_Data_valid`  out  1  single-cycle transmit request
- `Tx_busy`  in  1  transmitter busy

## Operation
- Command codes: `0xAA` RF write (addr, data); `0xBB` RF read (addr); `0xCC` ALU with operands (A, B, fun); `0xDD` ALU without operands (fun).
- Any other byte in IDLE is dropped; FSM stays in IDLE.
- Address bytes use bits `[addr_width-1:0]`; upper bits are ignored. `ALU_FUN` uses bits `[3:0]` of the fun byte.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, SEND0, WAIT0, SEND1, WAIT1.
- RF write path: IDLE -AA-> WR_ADDR -byte-> WR_DATA -byte-> IDLE.
  - The cycle after the data byte: `RF_WrEn` = 1, with `RF_Address` and `RF_WrData` held valid.
- RF read path: IDLE -BB-> RD_ADDR -byte-> RD_WAIT.
  - The cycle after the address byte: `RF_RdEn` = 1.
  - On `RF_RdData_valid`, capture the byte → SEND0 → WAIT0 → IDLE.
- ALU-with-operands path: IDLE -CC-> ALU_A -byte-> ALU_B -byte-> ALU_FUN.
  - Operand A is written to RF address 0; operand B is written to RF address 1. Each write strobes the cycle after its byte.
- ALU_FUN step: on the fun byte, `Clk_gate_EN` rises the next cycle and `ALU_EN` pulses the cycle after that. State becomes ALU_WAIT.
- ALU-without-operands path: IDLE -DD-> ALU_FUN.
- ALU result: on `ALU_OUT_valid`, capture the 16-bit result. Send the low byte (SEND0/WAIT0), then the high byte (SEND1/WAIT1), then return to IDLE.
- `Clk_gate_EN` deasserts in the cycle `ALU_OUT_valid` is seen.
- Send handshake:
  - SEND*: wait until `Tx_busy` = 0, then pulse `Tx_Data_valid` for one cycle with the byte held on `Tx_P_Data`.
  - WAIT*: ignore `Tx_busy` for the first cycle, then wait for `Tx_busy` = 0.
- `Rx_Data_valid` in any of RD_WAIT, ALU_WAIT, SEND*, WAIT* is dropped.
- No timeout. A lost `RF_RdData_valid` or `ALU_OUT_valid` stalls the FSM until reset.

## Timing
- Reset values: all strobes = 0, `Clk_gate_EN` = 0, `RF_Address` = 0, `RF_WrData` = 0, `ALU_FUN` = 0, `Tx_P_Data` = 0. State = IDLE; capture registers = 0.
- All outputs are registered.
- Strobe latency: `RF_WrEn`/`RF_RdEn` rise 1 cycle after the final `Rx_Data_valid` of the frame.
- ALU latency: `ALU_EN` rises 2 cycles after the fun byte.
- Transmit latency: `Tx_Data_valid` rises 1 cycle after response capture when `Tx_busy` = 0.
- Back-to-back bytes: `Rx_Data_valid` pulses may arrive in consecutive cycles; each is consumed.
- Write-to-idle: after a write frame, the FSM returns to IDLE in the same cycle as the strobe and accepts a new command the next cycle.
- Reset asserted mid-frame: immediate return to IDLE, all strobes and `Clk_gate_EN` cleared asynchronously.

## Structure
- Package `sys_cmd_pkg` holds:
  - command code constants (`CMD_RF_WR`, `CMD_RF_RD`, `CMD_ALU_OP`, `CMD_ALU_NOP`)
  - state encoding
  - operand RF addresses 0 and 1
- Sub-module `sys_resp_tx` implements the SEND/WAIT byte handshake. Inputs: a 1- or 2-byte payload and a start strobe. Outputs: a done strobe plus `Tx_P_Data` and `Tx_Data_valid`.

## Test plan
- RF write: bytes AA,05,3C → one `RF_WrEn` pulse with `RF_Address` = 5 and `RF_WrData` = 0x3C; no Tx activity.
- RF read: bytes BB,07, then `RF_RdData` = 0x9E with valid → `RF_RdEn` pulse with address 7, then one `Tx_Data_valid` with 0x9E.
- ALU with operands: bytes CC,12,34,01, then `ALU_OUT` = 0x0046 with valid.
  - Required: writes (0,0x12) and (1,0x34); `Clk_gate_EN` high, then `ALU_EN` pulse with `ALU_FUN` = 1.
  - Required: Tx bytes 0x46 then 0x00; `Clk_gate_EN` low afterward.
- Tx backpressure: hold `Tx_busy` = 1 for 50 cycles during a DD,02 response → no `Tx_Data_valid` until busy falls; exactly two pulses total.
- Unknown and dropped bytes: bytes 55, then AA,01,FF → 55 ignored and the write is executed. Bytes arriving during ALU_WAIT produce no RF strobes.
- Reset: assert `Reset` = 0 after CC,12 → all outputs zero; subsequent AA,02,11 executes a normal write.
